// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// ------------
// Shares the single-port synchronous data memory between the processor
// load/store path and the display scanout reader. At most one access is
// issued per cycle. The processor wins by default. A starvation counter forces
// a display burst after V_STARVE_MAX denied display cycles, and the burst is
// capped at V_BURST_MAX grants so processor stalls stay bounded.
//
// Handshake: p_req / v_req are the requesters' valid signals. ~p_stall (for the
// processor) and v_grant (for the display) are the matching ready signals. An
// access transfers in a cycle where valid and ready are both high. A requester
// that is not granted keeps its request, address and data stable until it is
// granted. Read data comes back exactly one cycle after the grant, flagged by
// p_rvalid / v_rvalid.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   p_req/p_we/p_addr/p_wdata   processor request
//   p_stall                 processor not granted this cycle (combinational)
//   p_rvalid/p_rdata        processor read return, one cycle after grant
//   v_req/v_addr            display read request
//   v_grant                 display granted this cycle (combinational)
//   v_rvalid/v_rdata        display read return, one cycle after grant
//   mem_addr/mem_wdata/mem_we/mem_rdata   single-port memory interface
//   dbg_state, dbg_starve_cnt   arbiter FSM state and starvation counter
//
// Optional build macro DMEM_ARB_STATS_EN adds the p_stall_cnt and v_wait_cnt
// outputs (32-bit wrapping event counters). Arbitration is the same either way.

module dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int V_STARVE_MAX = 16,
    parameter int V_BURST_MAX  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              p_req,
    input  logic                              p_we,
    input  logic [ADDR_W-1:0]                 p_addr,
    input  logic [DATA_W-1:0]                 p_wdata,
    output logic                              p_stall,
    output logic                              p_rvalid,
    output logic [DATA_W-1:0]                 p_rdata,
    input  logic                              v_req,
    input  logic [ADDR_W-1:0]                 v_addr,
    output logic                              v_grant,
    output logic                              v_rvalid,
    output logic [DATA_W-1:0]                 v_rdata,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    output logic                              mem_we,
    input  logic [DATA_W-1:0]                 mem_rdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]                       p_stall_cnt,
    output logic [31:0]                       v_wait_cnt,
`endif
    output logic [1:0]                        dbg_state,
    output logic [$clog2(V_STARVE_MAX+1)-1:0] dbg_starve_cnt
);

    localparam int SC_W = $clog2(V_STARVE_MAX + 1);
    localparam int BC_W = $clog2(V_BURST_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DISP = 2'd2
    } state_t;

    state_t            state;
    logic [SC_W-1:0]   starve_cnt;
    logic [BC_W-1:0]   burst_cnt;
    logic              burst_act;   // last display grant was part of a starvation burst
    logic [ADDR_W-1:0] addr_q;      // last issued address, held when idle
    logic [DATA_W-1:0] p_rdata_q;
    logic [DATA_W-1:0] v_rdata_q;

    logic grant_p;
    logic grant_v;
    logic burst_grant;

    // Grant decision. Everything is forced off while reset is high so the
    // memory never sees a write during reset.
    always_comb begin
        grant_p     = 1'b0;
        grant_v     = 1'b0;
        burst_grant = 1'b0;
        if (!reset) begin
            if (p_req && v_req && starve_cnt == SC_W'(V_STARVE_MAX)) begin
                grant_v     = 1'b1;
                burst_grant = 1'b1;
            end else if (p_req && v_req && state == DISP && burst_act &&
                         burst_cnt < BC_W'(V_BURST_MAX)) begin
                grant_v     = 1'b1;
                burst_grant = 1'b1;
            end else if (p_req) begin
                grant_p = 1'b1;
            end else if (v_req) begin
                grant_v = 1'b1;
            end
        end
    end

    assign p_stall   = p_req & ~grant_p & ~reset;
    assign v_grant   = grant_v;
    assign mem_we    = grant_p & p_we;
    assign mem_addr  = grant_p ? p_addr : (grant_v ? v_addr : addr_q);
    assign mem_wdata = grant_p ? p_wdata : '0;

    // Memory data is valid in the rvalid cycle itself; the _q copies keep the
    // last returned word on the outputs between returns.
    assign p_rdata = p_rvalid ? mem_rdata : p_rdata_q;
    assign v_rdata = v_rvalid ? mem_rdata : v_rdata_q;

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            burst_cnt  <= '0;
            burst_act  <= 1'b0;
            addr_q     <= '0;
            p_rvalid   <= 1'b0;
            v_rvalid   <= 1'b0;
            p_rdata_q  <= '0;
            v_rdata_q  <= '0;
        end else begin
            if (grant_p)
                state <= PROC;
            else if (grant_v)
                state <= DISP;
            else
                state <= IDLE;

            burst_act <= burst_grant;

            if (grant_v)
                starve_cnt <= '0;
            else if (v_req && starve_cnt != SC_W'(V_STARVE_MAX))
                starve_cnt <= starve_cnt + SC_W'(1);

            // Only display grants taken against a waiting processor count
            // toward the burst limit.
            if (grant_p || !p_req)
                burst_cnt <= '0;
            else if (grant_v)
                burst_cnt <= burst_cnt + BC_W'(1);

            addr_q   <= mem_addr;
            p_rvalid <= grant_p & ~p_we;
            v_rvalid <= grant_v;
            if (p_rvalid)
                p_rdata_q <= mem_rdata;
            if (v_rvalid)
                v_rdata_q <= mem_rdata;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_stall_cnt <= '0;
            v_wait_cnt  <= '0;
        end else begin
            if (p_stall)
                p_stall_cnt <= p_stall_cnt + 32'd1;
            if (v_req && !grant_v)
                v_wait_cnt <= v_wait_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        p_req;
    logic        p_we;
    logic [11:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_stall;
    logic        p_rvalid;
    logic [31:0] p_rdata;
    logic        v_req;
    logic [11:0] v_addr;
    logic        v_grant;
    logic        v_rvalid;
    logic [31:0] v_rdata;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;
    logic [4:0]  dbg_starve_cnt;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] p_stall_cnt;
    logic [31:0] v_wait_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tb_mem [0:4095];

    dmem_arbiter #(
        .ADDR_W(12), .DATA_W(32), .V_STARVE_MAX(16), .V_BURST_MAX(8)
    ) dut (
        .clk(clk), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .v_req(v_req), .v_addr(v_addr), .v_grant(v_grant),
        .v_rvalid(v_rvalid), .v_rdata(v_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata),
`ifdef DMEM_ARB_STATS_EN
        .p_stall_cnt(p_stall_cnt), .v_wait_cnt(v_wait_cnt),
`endif
        .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous single-port memory model: data one cycle after address
    always @(posedge clk) begin
        if (mem_we)
            tb_mem[mem_addr] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: apply inputs at negedge, settle, then caller checks
    task automatic drive(input logic pr, input logic pw, input logic [11:0] pa,
                         input logic [31:0] pd, input logic vr, input logic [11:0] va);
        @(negedge clk);
        p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        v_req = vr; v_addr = va;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        p_req = 1'b0; p_we = 1'b0; v_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic exp_d;
        logic [31:0] e;
        for (int i = 0; i < 4096; i++) tb_mem[i] = 32'h1000 + i;
        mem_rdata = '0;
        reset = 1'b1;
        p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        v_req = 1'b0; v_addr = '0;

        // reset state, with requests present while reset is held
        repeat (2) @(negedge clk);
        p_req = 1'b1; p_we = 1'b1; v_req = 1'b1; p_addr = 12'd9; v_addr = 12'd9;
        #1;
        chk("rst_p_stall", p_stall, 0);
        chk("rst_v_grant", v_grant, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_p_rvalid", p_rvalid, 0);
        chk("rst_v_rvalid", v_rvalid, 0);
        chk("rst_p_rdata", p_rdata, 0);
        chk("rst_v_rdata", v_rdata, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_starve", dbg_starve_cnt, 0);
        pulse_reset();

        // display only: back-to-back reads 0..9
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 1, 12'(i));
            chk("v_only_grant", v_grant, 1);
            chk("v_only_addr", mem_addr, i);
            if (i > 0) begin
                chk("v_only_rvalid", v_rvalid, 1);
                chk("v_only_rdata", v_rdata, exp_q.pop_front());
            end
            exp_q.push_back(32'h1000 + i);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("v_only_rvalid_last", v_rvalid, 1);
        chk("v_only_rdata_last", v_rdata, exp_q.pop_front());
        drive(0, 0, 0, 0, 0, 0);
        chk("v_only_rvalid_off", v_rvalid, 0);
        chk("v_only_rdata_hold", v_rdata, 32'h1009);
        chk("v_only_addr_hold", mem_addr, 9);

        // processor only: write 42 to 5, read 5, write 7 to 6, read 6
        drive(1, 1, 5, 42, 0, 0);
        chk("p_wr5_stall", p_stall, 0);
        chk("p_wr5_we", mem_we, 1);
        chk("p_wr5_addr", mem_addr, 5);
        chk("p_wr5_wdata", mem_wdata, 42);
        drive(1, 0, 5, 0, 0, 0);
        chk("p_rd5_stall", p_stall, 0);
        chk("p_rd5_we", mem_we, 0);
        chk("p_wr_no_rvalid", p_rvalid, 0);
        drive(1, 1, 6, 7, 0, 0);
        chk("p_wr6_we", mem_we, 1);
        chk("p_rd5_rvalid", p_rvalid, 1);
        chk("p_rd5_rdata", p_rdata, 42);
        drive(1, 0, 6, 0, 0, 0);
        chk("p_rd6_we", mem_we, 0);
        chk("p_rd6_stall", p_stall, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("p_rd6_rvalid", p_rvalid, 1);
        chk("p_rd6_rdata", p_rdata, 7);
        chk("p_idle_stall", p_stall, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("p_rvalid_off", p_rvalid, 0);
        chk("p_rdata_hold", p_rdata, 7);
        chk("p_addr_hold", mem_addr, 6);

        // reset while a display read is granted
        drive(0, 0, 0, 0, 1, 12'd3);
        chk("mid_grant", v_grant, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_grant", v_grant, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_vrdata", v_rdata, 0);
        chk("mid_rst_prdata", p_rdata, 0);
        drive(0, 0, 0, 0, 1, 12'd3);
        chk("mid_rst_vrvalid", v_rvalid, 0);
        chk("mid_rst_state", dbg_state, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 1, 12'd4);
        chk("post_rst_grant", v_grant, 1);
        chk("post_rst_addr", mem_addr, 4);
        drive(0, 0, 0, 0, 0, 0);
        chk("post_rst_rvalid", v_rvalid, 1);
        chk("post_rst_rdata", v_rdata, 32'h1004);

        // continuous contention: 16 processor, 8 display, repeating
        pulse_reset();
        for (int k = 0; k < 48; k++) begin
            drive(1, 0, 12'(k), 0, 1, 12'(100 + k));
            exp_d = ((k % 24) >= 16);
            chk($sformatf("cont_vgrant_%0d", k), v_grant, exp_d);
            chk($sformatf("cont_pstall_%0d", k), p_stall, exp_d);
        end
        drive(0, 0, 0, 0, 0, 0);
`ifdef DMEM_ARB_STATS_EN
        chk("stat_p_stall_cnt", p_stall_cnt, 16);
        chk("stat_v_wait_cnt", v_wait_cnt, 32);
`endif

        // v_req drops after 3 burst cycles
        pulse_reset();
        for (int k = 0; k < 19; k++) begin
            drive(1, 0, 0, 0, 1, 12'd1);
            chk($sformatf("drop_vgrant_%0d", k), v_grant, (k >= 16));
        end
        drive(1, 0, 0, 0, 0, 0);
        chk("drop_p_granted", p_stall, 0);
        chk("drop_starve", dbg_starve_cnt, 0);
        chk("drop_state_disp", dbg_state, 2);
        drive(1, 0, 0, 0, 1, 12'd1);
        chk("drop_p_again", p_stall, 0);
        chk("drop_v_denied", v_grant, 0);
        chk("drop_state_proc", dbg_state, 1);
        e = {27'd0, dbg_starve_cnt};
        chk("drop_starve_held", e, 0);
        drive(0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the processor's load/store path and the display scanout engine that reads board state for the VGA.
- Sits between `my_processor`, the display reader and `my_dmem` inside `skeleton`.
- Issues at most one memory access per cycle.
- Default priority goes to the processor. A starvation counter guarantees display bandwidth. A burst limit bounds processor stall time.

Parameters:
- ADDR_W, 12, data memory word-address width
- DATA_W, 32, data word width
- V_STARVE_MAX, 16, consecutive denied display-request cycles before display gets priority
- V_BURST_MAX, 8, maximum consecutive display grants while processor is requesting

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- p_req  input  1  processor requests memory access this cycle
- p_we  input  1  processor access is a write
- p_addr  input  ADDR_W  processor word address
- p_wdata  input  DATA_W  processor write data
- p_stall  output  1  processor request not granted this cycle; processor freezes pipeline
- p_rvalid  output  1  processor read data valid (registered)
- p_rdata  output  DATA_W  processor read data
- v_req  input  1  display read request
- v_addr  input  ADDR_W  display word address
- v_grant  output  1  display request accepted this cycle
- v_rvalid  output  1  display read data valid (registered)
- v_rdata  output  DATA_W  display read data
- mem_addr  output  ADDR_W  to dmem address
- mem_wdata  output  DATA_W  to dmem data
- mem_we  output  1  to dmem write enable
- mem_rdata  input  DATA_W  from dmem, valid one cycle after address

Behaviour:
- FSM states:
  - IDLE: no grant issued last cycle.
  - PROC: processor granted.
  - DISP: display granted.
- State and the grant decision are computed combinationally from the current state, starvation counter (starve_cnt), burst counter (burst_cnt), p_req and v_req. Registers update on clk.
- Grant rules, evaluated in order:
  - (1) p_req & v_req & (starve_cnt == V_STARVE_MAX) -> grant display.
  - (2) p_req & v_req & state==DISP & burst_cnt < V_BURST_MAX & starve-triggered burst active -> grant display.
  - (3) p_req -> grant processor.
  - (4) v_req -> grant display.
  - (5) otherwise no grant.
- Starvation-triggered burst: entered by rule 1. It continues while v_req stays high and burst_cnt < V_BURST_MAX. It ends on v_req low or on reaching the limit. After a burst ends at the limit, the processor is granted for at least one cycle if p_req is high.
- starve_cnt:
  - increments (saturating at V_STARVE_MAX) on each cycle with v_req & ~v_grant;
  - clears on any v_grant;
  - holds when v_req is low.
- burst_cnt:
  - increments on each display grant while p_req is high;
  - clears on any processor grant or on any cycle where p_req is low.
- Outputs on the granted access:
  - mem_addr and mem_wdata mux from the granted port. With no grant, mem_addr holds the previous value.
  - mem_we = p_req & p_we & processor granted. Never asserted for display.
- p_stall = p_req & ~(processor granted). Combinational. Zero when p_req is low.
- v_grant = display granted. Combinational.
- Read return:
  - A granted processor read sets p_rvalid the next cycle, with p_rdata = mem_rdata.
  - A granted display read likewise sets v_rvalid the next cycle, with v_rdata = mem_rdata.
  - Processor writes do not assert p_rvalid.
  - rdata outputs hold their last value when not valid.
- Latency: 1 cycle from grant to rvalid. Back-to-back grants give one rvalid per cycle.
- Reset (async) clears:
  - state = IDLE, starve_cnt = 0, burst_cnt = 0;
  - p_rvalid = 0, v_rvalid = 0;
  - p_rdata = 0, v_rdata = 0, mem_addr = 0.
- Reset also applies to combinational outputs: p_stall, v_grant and mem_we are 0 while reset is high, regardless of requests.
- Reset mid-access: the pending rvalid is dropped.

Optional Feature:
- DMEM_ARB_STATS_EN: adds output p_stall_cnt (32 bits) and output v_wait_cnt (32 bits).
  - p_stall_cnt counts cycles with p_stall high.
  - v_wait_cnt counts cycles with v_req & ~v_grant.
  - Both counters are wrapping, cleared by reset, and visible to the bench.
- Without the macro, neither port nor the counters exist. Arbitration is identical either way.

Test Plan:
- Only p_req: alternating reads/writes to addresses 5, 6 -> p_stall = 0 every cycle; mem_we high on write cycles only; p_rvalid one cycle after each read with stored data (write 42 to 5, read 5 -> 42).
- Only v_req: continuous reads at 0..9 -> v_grant every cycle; v_rvalid/v_rdata one cycle later in order.
- Both requesting continuously, V_STARVE_MAX = 16, V_BURST_MAX = 8:
  - processor granted 16 cycles;
  - then display granted 8 consecutive cycles with p_stall = 1;
  - then processor again;
  - pattern repeats.
- v_req drops after 3 display burst cycles -> processor granted the next cycle; starve_cnt = 0.
- Assert reset while a display read is granted -> v_rvalid stays 0, all outputs at reset values; after release, the first request is granted immediately.
- With DMEM_ARB_STATS_EN defined, the continuous-contention case over 48 cycles -> p_stall_cnt = 16 and v_wait_cnt = 32.
